// File: rtl/exp_pkg.sv
// Shared constants, rounding helpers and types for the exp multiplier generator.
// ln(2) and ln(1+2^-i) are kept at 24 fraction bits and rounded to the datapath width.
package exp_pkg;

  localparam int CONST_FRAC = 24;
  localparam int STEP_W     = 6;
  localparam logic [31:0] LN2_24 = 32'd11629080;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_APPLY, S_DONE} state_t;

  typedef struct packed {
    state_t              state;
    logic                int_step;
    logic [STEP_W-1:0]   step;
  } dbg_t;

  function automatic logic [31:0] ln1p_24(input int i);
    case (i)
      1:       return 32'd6802576;
      2:       return 32'd3743728;
      3:       return 32'd1976071;
      4:       return 32'd1017112;
      5:       return 32'd516263;
      6:       return 32'd260117;
      7:       return 32'd130563;
      8:       return 32'd65408;
      9:       return 32'd32736;
      10:      return 32'd16376;
      11:      return 32'd8190;
      12:      return 32'd4096;
      13:      return 32'd2048;
      14:      return 32'd1024;
      15:      return 32'd512;
      16:      return 32'd256;
      default: return 32'd0;
    endcase
  endfunction

  // Round-to-nearest from 24 fraction bits down to frac_w bits.
  function automatic logic [31:0] round_q(input logic [31:0] c, input int frac_w);
    return (c + (32'd1 << (CONST_FRAC - 1 - frac_w))) >> (CONST_FRAC - frac_w);
  endfunction

  function automatic logic [31:0] ln2_q(input int frac_w);
    return round_q(LN2_24, frac_w);
  endfunction

  function automatic logic [31:0] ln1p_q(input int i, input int frac_w);
    return round_q(ln1p_24(i), frac_w);
  endfunction

  function automatic logic [31:0] ln1p_min(input int frac_w);
    logic [31:0] m;
    m = ln1p_q(1, frac_w);
    for (int i = 2; i <= frac_w; i++) begin
      if (ln1p_q(i, frac_w) != 32'd0 && ln1p_q(i, frac_w) < m) m = ln1p_q(i, frac_w);
    end
    return m;
  endfunction

  function automatic logic [63:0] fix_one(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

endpackage

// File: rtl/exp_mul_gen_param_term_select.sv
// Combinational step chooser: picks the largest power-of-two step or the
// largest (1+2^-i) factor that still fits in the current residual.
module exp_term_select
  import exp_pkg::*;
#(
  parameter int IN_INT_W  = 4,
  parameter int FRAC_W    = 11,
  parameter int MUL_INT_W = 15,
  localparam int RES_W = IN_INT_W + FRAC_W,
  localparam int MUL_W = MUL_INT_W + FRAC_W
) (
  input  logic [RES_W-1:0]  residual,
  output logic              int_step,
  output logic [STEP_W-1:0] step,
  output logic [MUL_W-1:0]  factor,
  output logic [RES_W-1:0]  subtrahend
);

  localparam logic [31:0]      LN2_Q = ln2_q(FRAC_W);
  localparam logic [MUL_W-1:0] ONE   = MUL_W'(fix_one(FRAC_W));

  logic [31:0] res32;
  assign res32 = 32'(residual);

  always_comb begin
    int_step   = 1'b0;
    step       = '0;
    factor     = ONE;
    subtrahend = '0;
    if (res32 >= LN2_Q) begin
      int_step = 1'b1;
      // Ascending scan: the last k that fits wins; capped at MUL_INT_W-1 so the factor fits.
      for (int k = 1; k < MUL_INT_W; k++) begin
        if (32'(k) * LN2_Q <= res32) begin
          step       = STEP_W'(k);
          factor     = ONE << k;
          subtrahend = RES_W'(32'(k) * LN2_Q);
        end
      end
    end else begin
      // Descending scan so the smallest qualifying i (largest factor) wins.
      for (int i = FRAC_W; i >= 1; i--) begin
        if (ln1p_q(i, FRAC_W) <= res32) begin
          step       = STEP_W'(i);
          factor     = ONE + (ONE >> i);
          subtrahend = RES_W'(ln1p_q(i, FRAC_W));
        end
      end
    end
  end

endmodule

// File: rtl/exp_mul_gen_param.sv
// Multiplier generator: decomposes X into up to N_TERMS factors whose product ~ exp(X).
// Optional resid_out port under `define EXP_MUL_GEN_PARAM_RESID_EN.
module exp_mul_gen_param
  import exp_pkg::*;
#(
  parameter int IN_INT_W  = 4,
  parameter int FRAC_W    = 11,
  parameter int MUL_INT_W = 15,
  parameter int N_TERMS   = 6,
  localparam int RES_W = IN_INT_W + FRAC_W,
  localparam int MUL_W = MUL_INT_W + FRAC_W,
  localparam int CNT_W = $clog2(N_TERMS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RES_W-1:0]         x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_TERMS*MUL_W-1:0] mul_bus,
  output logic [CNT_W-1:0]         term_count,
  output logic                     ovf,
  output dbg_t                     dbg
`ifdef EXP_MUL_GEN_PARAM_RESID_EN
  ,
  output logic [RES_W-1:0]         resid_out
`endif
);

  // Handshakes: a transfer happens on a rising edge with valid and ready both high;
  // out_valid holds with stable data until out_ready, and in_ready is high only in IDLE.

  localparam logic [RES_W-1:0] MIN_STEP = RES_W'(ln1p_min(FRAC_W));
  localparam logic [MUL_W-1:0] ONE      = MUL_W'(fix_one(FRAC_W));

  state_t              state, state_nxt;
  logic                rdy_en;
  logic [RES_W-1:0]    resid, resid_sub;
  logic [CNT_W-1:0]    term_cnt;
  logic [MUL_W-1:0]    fac_q [N_TERMS];
  logic                sel_int, ts_int;
  logic [STEP_W-1:0]   sel_step, ts_step;
  logic [MUL_W-1:0]    sel_factor, ts_factor;
  logic [RES_W-1:0]    sel_sub, ts_sub;
  logic                accept, last_term;

  exp_term_select #(
    .IN_INT_W  (IN_INT_W),
    .FRAC_W    (FRAC_W),
    .MUL_INT_W (MUL_INT_W)
  ) u_sel (
    .residual   (resid),
    .int_step   (ts_int),
    .step       (ts_step),
    .factor     (ts_factor),
    .subtrahend (ts_sub)
  );

  assign accept    = (state == S_IDLE) && in_valid && rdy_en;
  assign resid_sub = resid - sel_sub;
  assign last_term = (resid_sub < MIN_STEP) || (term_cnt == CNT_W'(N_TERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rdy_en;
        if (accept) state_nxt = (x_in < MIN_STEP) ? S_DONE : S_SELECT;
      end
      S_SELECT: state_nxt = S_APPLY;
      S_APPLY:  state_nxt = last_term ? S_DONE : S_SELECT;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      resid      <= '0;
      term_cnt   <= '0;
      sel_int    <= 1'b0;
      sel_step   <= '0;
      sel_factor <= ONE;
      sel_sub    <= '0;
      for (int j = 0; j < N_TERMS; j++) fac_q[j] <= ONE;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        resid    <= x_in;
        term_cnt <= '0;
        for (int j = 0; j < N_TERMS; j++) fac_q[j] <= ONE;
      end
      if (state == S_SELECT) begin
        sel_int    <= ts_int;
        sel_step   <= ts_step;
        sel_factor <= ts_factor;
        sel_sub    <= ts_sub;
      end
      if (state == S_APPLY) begin
        for (int j = 0; j < N_TERMS; j++) begin
          if (CNT_W'(j) == term_cnt) fac_q[j] <= sel_factor;
        end
        resid    <= resid_sub;
        term_cnt <= term_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_TERMS; g++) begin : g_bus
    assign mul_bus[g*MUL_W +: MUL_W] = fac_q[g];
  end

  assign term_count   = term_cnt;
  assign ovf          = (state == S_DONE) && (term_cnt == CNT_W'(N_TERMS)) && (resid >= MIN_STEP);
  assign dbg.state    = state;
  assign dbg.int_step = sel_int;
  assign dbg.step     = sel_step;

`ifdef EXP_MUL_GEN_PARAM_RESID_EN
  assign resid_out = out_valid ? resid : '0;
`endif

endmodule

// File: tb/tb_exp_mul_gen_param.sv
// Directed bench for exp_mul_gen_param: default-parameter instance plus a
// small N_TERMS=2 / FRAC_W=8 instance for the truncation case.
module tb_exp_mul_gen_param;
  import exp_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, ovf;
  logic [14:0]   x_in;
  logic [155:0]  mul_bus;
  logic [2:0]    term_count;
  dbg_t          dbg;
`ifdef EXP_MUL_GEN_PARAM_RESID_EN
  logic [14:0]   resid_out;
  logic [11:0]   b_resid_out;
`endif

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [11:0]   b_x_in;
  logic [45:0]   b_mul_bus;
  logic [1:0]    b_term_count;
  dbg_t          b_dbg;

  int n_checks = 0;
  int n_err    = 0;
  logic [25:0] exp_q[$];

  exp_mul_gen_param dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .mul_bus(mul_bus),
    .term_count(term_count), .ovf(ovf), .dbg(dbg)
`ifdef EXP_MUL_GEN_PARAM_RESID_EN
    , .resid_out(resid_out)
`endif
  );

  exp_mul_gen_param #(.IN_INT_W(4), .FRAC_W(8), .MUL_INT_W(15), .N_TERMS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .x_in(b_x_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .mul_bus(b_mul_bus),
    .term_count(b_term_count), .ovf(b_ovf), .dbg(b_dbg)
`ifdef EXP_MUL_GEN_PARAM_RESID_EN
    , .resid_out(b_resid_out)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push6(input logic [25:0] f0, f1, f2, f3, f4, f5);
    exp_q.push_back(f0); exp_q.push_back(f1); exp_q.push_back(f2);
    exp_q.push_back(f3); exp_q.push_back(f4); exp_q.push_back(f5);
  endtask

  task automatic check_factors(input string tag);
    logic [25:0] f;
    for (int j = 0; j < 6; j++) begin
      f = exp_q.pop_front();
      check($sformatf("%s_fac%0d", tag, j), 64'(mul_bus[j*26 +: 26]), 64'(f));
    end
  endtask

  // Present x, wait for acceptance, then count cycles until out_valid.
  task automatic send(input logic [14:0] x, output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = x;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic verify(input string tag, input int lat, input int exp_lat,
                        input int exp_tc, input logic exp_ovf);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_tc"}, 64'(term_count), 64'(exp_tc));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    check_factors(tag);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_x_in = '0;

    // Reset values
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_tc", 64'(term_count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    push6(26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    check_factors("rst");
    check("rst_b_fac0", 64'(b_mul_bus[22:0]), 64'd256);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_state", 64'(dbg.state), 64'(S_IDLE));

    // 2250 = 1420 + 830: one integer step then i=1
    send(15'd2250, lat);
    push6(26'd4096, 26'd3072, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    verify("x2250", lat, 5, 2, 1'b0);
    release_out("x2250");

    // Zero argument skips straight to DONE
    send(15'd0, lat);
    push6(26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    verify("x0", lat, 1, 0, 1'b0);
    release_out("x0");

    // Max argument: k clamps to 14, then k=9, then i=5,6,8,9 exactly consume it
    send(15'd32767, lat);
    push6(26'd33554432, 26'd1048576, 26'd2112, 26'd2080, 26'd2056, 26'd2052);
    verify("xmax", lat, 13, 6, 1'b0);
    release_out("xmax");

    // 1271: i=1,3,4,5,8,9 leaves residual 1 -> overflow
    send(15'd1271, lat);
    push6(26'd3072, 26'd2304, 26'd2176, 26'd2112, 26'd2056, 26'd2052);
    verify("x1271", lat, 13, 6, 1'b1);
`ifdef EXP_MUL_GEN_PARAM_RESID_EN
    check("x1271_resid", 64'(resid_out), 64'd1);
`endif

    // Hold DONE without out_ready while a new input is offered
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = 15'd100;
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("hold%0d_tc", c), 64'(term_count), 64'd6);
      check($sformatf("hold%0d_fac0", c), 64'(mul_bus[25:0]), 64'd3072);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_drop", 64'(out_valid), 64'd0);
    check("hold_ovf_clear", 64'(ovf), 64'd0);

    // Exactly ln2: single integer term
    send(15'd1420, lat);
    push6(26'd4096, 26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    verify("x1420", lat, 3, 1, 1'b0);
    release_out("x1420");

    // 1287 = 830 + 457: i=1 then i=2
    send(15'd1287, lat);
    push6(26'd3072, 26'd2560, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    verify("x1287", lat, 5, 2, 1'b0);
    release_out("x1287");

    // Reset asserted during APPLY of term 3
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 15'd1271;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!(dbg.state == S_APPLY && term_count == 3'd3) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("mid_apply_reached", 64'(term_count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_tc", 64'(term_count), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_state", 64'(dbg.state), 64'(S_IDLE));
    push6(26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    check_factors("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(15'd2250, lat);
    push6(26'd4096, 26'd3072, 26'd2048, 26'd2048, 26'd2048, 26'd2048);
    verify("after_rst", lat, 5, 2, 1'b0);
    release_out("after_rst");

    // Small instance: 338 = 177 + 104 + 57 needs three steps, only two allowed
    @(negedge clk);
    b_in_valid = 1'b1;
    b_x_in     = 12'd338;
    guard = 0;
    while (!b_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("b_accept_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b_lat", 64'(lat), 64'd5);
    check("b_tc", 64'(b_term_count), 64'd2);
    check("b_ovf", 64'(b_ovf), 64'd1);
    check("b_fac0", 64'(b_mul_bus[22:0]), 64'd512);
    check("b_fac1", 64'(b_mul_bus[45:23]), 64'd384);
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("b_drop", 64'(b_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
